// File: rtl/btn_entry_pkg.sv
// Shared types and codes for the front-panel number-entry block and the display decoder.
package btn_entry_pkg;

  typedef enum logic [2:0] {
    S_PROMPT,
    S_EDIT,
    S_CONV,
    S_WR,
    S_CHECK
  } state_e;

  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;

  localparam int NUM_BTN = 4;
  localparam int BTN_INC = 0;
  localparam int BTN_CUR = 1;
  localparam int BTN_SGN = 2;
  localparam int BTN_ENT = 3;

  // d2*100 + d1*10 + d0 using only shifts and adds (100 = 64+32+4, 10 = 8+2).
  function automatic logic [8:0] bcd3_to_bin(input logic [1:0] d2,
                                             input logic [3:0] d1,
                                             input logic [3:0] d0);
    logic [8:0] h, t, u;
    h = 9'(d2);
    t = 9'(d1);
    u = 9'(d0);
    return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;
  endfunction

endpackage

// File: rtl/btn_entry_debounce.sv
// One push-button front end: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      s3      <= s2;
      level_d <= level;
      // Any change of the synchronized level restarts the stability window.
      if (s2 != s3) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/btn_entry.sv
// Signed 3-digit decimal entry: debounced buttons drive a digit editor with live display preview.
module btn_entry
  import btn_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [7:0] bin,
  output logic       sgn,
  output logic       wr_enable,
  output logic       led0_sel,
  output logic [1:0] msg,
  output logic [1:0] dot,
  output logic       entry_valid,
  output logic [7:0] entry_value,
  output logic       entry_sgn
);

  logic [NUM_BTN-1:0] level, press, act;
  state_e             state, state_n;
  logic [3:0]         d0, d1;
  logic [1:0]         d2, cursor;
  logic               sign;
  logic [8:0]         sum;
  logic               in_range;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign in_range = ~sum[8];
  assign dot      = cursor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_PROMPT;
    else     state <= state_n;
  end

  always_comb begin
    act     = '0;
    state_n = state;
    // Simultaneous presses: only the highest-priority button survives.
    if      (press[BTN_ENT]) act[BTN_ENT] = 1'b1;
    else if (press[BTN_SGN]) act[BTN_SGN] = 1'b1;
    else if (press[BTN_CUR]) act[BTN_CUR] = 1'b1;
    else if (press[BTN_INC]) act[BTN_INC] = 1'b1;
    unique case (state)
      S_PROMPT: if (|press) state_n = S_EDIT;
      S_EDIT: begin
        if (act[BTN_ENT])                     state_n = S_CHECK;
        else if (act[BTN_INC] | act[BTN_SGN]) state_n = S_CONV;
      end
      S_CONV:  state_n = S_WR;
      S_WR:    state_n = S_EDIT;
      S_CHECK: state_n = in_range ? S_PROMPT : S_EDIT;
      default: state_n = S_PROMPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      cursor      <= '0;
      sign        <= 1'b0;
      sum         <= '0;
      bin         <= '0;
      sgn         <= 1'b0;
      wr_enable   <= 1'b0;
      led0_sel    <= 1'b0;
      msg         <= MSG_VAL;
      entry_valid <= 1'b0;
      entry_value <= '0;
      entry_sgn   <= 1'b0;
    end else begin
      wr_enable   <= 1'b0;
      entry_valid <= 1'b0;
      led0_sel    <= 1'b1;
      unique case (state)
        S_PROMPT: if (|press) msg <= MSG_NUM;
        S_EDIT: begin
          if (act[BTN_INC]) begin
            unique case (cursor)
              2'd0:    d0 <= (d0 == 4'd9) ? 4'd0 : d0 + 4'd1;
              2'd1:    d1 <= (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
              default: d2 <= (d2 == 2'd2) ? 2'd0 : d2 + 2'd1;
            endcase
          end
          if (act[BTN_CUR]) cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
          if (act[BTN_SGN]) sign <= ~sign;
          // Commit is issued on the way into S_CHECK so the pulse lands one cycle after Enter.
          if (act[BTN_ENT] && in_range) begin
            entry_valid <= 1'b1;
            entry_value <= sum[7:0];
            entry_sgn   <= sign & (sum != 9'd0);
          end
        end
        S_CONV: sum <= bcd3_to_bin(d2, d1, d0);
        S_WR: begin
          if (in_range) begin
            bin       <= sum[7:0];
            sgn       <= sign;
            wr_enable <= 1'b1;
            msg       <= MSG_NUM;
          end else begin
            msg <= MSG_ERR;
          end
        end
        S_CHECK: begin
          if (in_range) begin
            d0     <= '0;
            d1     <= '0;
            d2     <= '0;
            cursor <= '0;
            sign   <= 1'b0;
            sum    <= '0;
            msg    <= MSG_VAL;
          end else begin
            msg <= MSG_ERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_entry.sv
// Directed bench for btn_entry with a digit-level reference model and pulse scoreboard.
module tb_btn_entry;
  import btn_entry_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic [7:0] bin, entry_value;
  logic       sgn, wr_enable, led0_sel, entry_valid, entry_sgn;
  logic [1:0] msg, dot;

  btn_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .bin(bin), .sgn(sgn), .wr_enable(wr_enable),
    .led0_sel(led0_sel), .msg(msg), .dot(dot), .entry_valid(entry_valid),
    .entry_value(entry_value), .entry_sgn(entry_sgn)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit run = 0;

  // Reference model: digits, cursor, sign and the displayed/committed values.
  int m_d[3];
  int m_cur, m_msg, m_bin, m_sgn, m_ev, m_es;
  bit m_sign, m_prompt;
  int wr_q[$];
  int ev_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_d = '{0, 0, 0};
    m_cur = 0; m_sign = 0; m_prompt = 1;
    m_msg = 2; m_bin = 0; m_sgn = 0; m_ev = 0; m_es = 0;
    wr_q.delete(); ev_q.delete();
  endtask

  function automatic int m_val();
    return m_d[2] * 100 + m_d[1] * 10 + m_d[0];
  endfunction

  task automatic m_preview();
    int v;
    v = m_val();
    if (v <= 255) begin
      m_bin = v; m_sgn = m_sign; m_msg = 0;
      wr_q.push_back(v + 256 * int'(m_sign));
    end else m_msg = 3;
  endtask

  task automatic m_apply(input logic [3:0] mask);
    int b, v;
    b = mask[3] ? 3 : mask[2] ? 2 : mask[1] ? 1 : 0;
    if (m_prompt) begin
      m_prompt = 0; m_msg = 0;
      return;
    end
    case (b)
      0: begin
        m_d[m_cur] = (m_d[m_cur] + 1) % ((m_cur == 2) ? 3 : 10);
        m_preview();
      end
      1: m_cur = (m_cur + 1) % 3;
      2: begin m_sign = !m_sign; m_preview(); end
      default: begin
        v = m_val();
        if (v <= 255) begin
          m_ev = v; m_es = (m_sign && v != 0) ? 1 : 0;
          ev_q.push_back(m_ev + 256 * m_es);
          m_d = '{0, 0, 0}; m_cur = 0; m_sign = 0; m_prompt = 1; m_msg = 2;
        end else m_msg = 3;
      end
    endcase
  endtask

  // Pulse scoreboard: every wr_enable / entry_valid must match the next expected event.
  int e;
  always @(posedge clk) begin
    #1;
    if (!rst && run) begin
      if (wr_enable && entry_valid) chk("wr_and_valid_overlap", 1, 0);
      if (wr_enable) begin
        if (wr_q.size() == 0) chk("unexpected_wr_enable", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_bin", int'(bin), e % 256);
          chk("wr_sgn", int'(sgn), e / 256);
        end
      end
      if (entry_valid) begin
        if (ev_q.size() == 0) chk("unexpected_entry_valid", 1, 0);
        else begin
          e = ev_q.pop_front();
          chk("entry_value", int'(entry_value), e % 256);
          chk("entry_sgn", int'(entry_sgn), e / 256);
        end
      end
      chk("led0_sel", int'(led0_sel), 1);
    end
  end

  task automatic settle();
    chk("pending_wr", wr_q.size(), 0);
    chk("pending_commit", ev_q.size(), 0);
    wr_q.delete(); ev_q.delete();
    chk("msg", int'(msg), m_msg);
    chk("dot", int'(dot), m_cur);
    chk("bin", int'(bin), m_bin);
    chk("sgn", int'(sgn), m_sgn);
    chk("held_entry_value", int'(entry_value), m_ev);
    chk("held_entry_sgn", int'(entry_sgn), m_es);
  endtask

  task automatic press(input logic [3:0] mask);
    m_apply(mask);
    @(negedge clk) btn = mask;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    settle();
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  task automatic check_reset_values();
    chk("rst_bin", int'(bin), 0);
    chk("rst_sgn", int'(sgn), 0);
    chk("rst_wr_enable", int'(wr_enable), 0);
    chk("rst_led0_sel", int'(led0_sel), 0);
    chk("rst_msg", int'(msg), 2);
    chk("rst_dot", int'(dot), 0);
    chk("rst_entry_valid", int'(entry_valid), 0);
    chk("rst_entry_value", int'(entry_value), 0);
    chk("rst_entry_sgn", int'(entry_sgn), 0);
  endtask

  initial begin
    bit found;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(posedge clk) #1;
    chk("led0_sel_after_reset", int'(led0_sel), 1);
    run = 1;

    // Wake from prompt: no edit, no write.
    press(4'b0001);
    chk("wake_msg_literal", int'(msg), 0);

    // 23 on the display, cursor on tens.
    press_n(4'b0001, 3);
    press(4'b0010);
    press_n(4'b0001, 2);
    chk("preview_bin_literal", int'(bin), 23);
    chk("preview_dot_literal", int'(dot), 1);

    // Sign and commit.
    press(4'b0100);
    press(4'b1000);
    chk("commit_value_literal", int'(entry_value), 23);
    chk("commit_sgn_literal", int'(entry_sgn), 1);
    chk("commit_msg_literal", int'(msg), 2);

    // Overflow to 260, rejected Enter, then 255/256 boundary.
    press(4'b0001);
    press_n(4'b0010, 2);
    press_n(4'b0001, 2);
    press_n(4'b0010, 2);
    press_n(4'b0001, 6);
    chk("overflow_msg_literal", int'(msg), 3);
    press(4'b1000);
    chk("overflow_no_commit_value", int'(entry_value), 23);
    press_n(4'b0001, 9);
    press_n(4'b0010, 2);
    press_n(4'b0001, 5);
    chk("max_bin_literal", int'(bin), 255);
    press(4'b0001);
    press(4'b1000);
    press_n(4'b0001, 9);
    press(4'b1000);

    // Units wrap back to 0.
    press(4'b0001);
    press_n(4'b0001, 10);
    chk("wrap_bin_literal", int'(bin), 0);

    // Bounce: toggling every 2 cycles must never produce a press.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) btn[0] = ~btn[0];
      @(negedge clk);
    end
    btn = '0;
    repeat (20) @(negedge clk);
    settle();

    // Negative zero commits as positive.
    press(4'b0100);
    press(4'b1000);
    chk("neg_zero_sgn_literal", int'(entry_sgn), 0);

    // Enter and increment together: commit only.
    press(4'b0001);
    press(4'b0001);
    press(4'b1001);
    chk("priority_value_literal", int'(entry_value), 1);

    // Reset while the write is pending.
    press(4'b0001);
    @(negedge clk) btn = 4'b0001;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk) #2;
      if (u_dut.state == S_WR) found = 1;
    end
    chk("reached_s_wr", int'(found), 1);
    run = 0;
    rst = 1'b1;
    #1;
    check_reset_values();
    btn = '0;
    repeat (3) @(negedge clk);
    m_reset();
    rst = 1'b0;
    @(posedge clk) #1;
    run = 1;
    repeat (20) @(negedge clk);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
